// File: rtl/ball_engine.sv
// Ball-motion engine: serve/play/miss FSM with wall, zoned-paddle and brick-map collisions, advanced once per frame tick.
// Optional BALL_SPEEDUP_EN: each paddle bounce raises the speed by one, saturating at MAX_SPEED.
module ball_engine #(
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int BALL_SIZE  = 7,
    parameter int PADDLE_W   = 100,
    parameter int PADDLE_Y   = 440,
    parameter int SPEED      = 4,
    parameter int MAX_SPEED  = 8,
    parameter int BRICK_COLS = 5,
    parameter int BRICK_ROWS = 5,
    parameter int BRICK_X0   = 40,
    parameter int BRICK_Y0   = 40,
    parameter int BRICK_PX   = 120,
    parameter int BRICK_PY   = 50,
    parameter int BRICK_W    = 80,
    parameter int BRICK_H    = 30,
    parameter int MISS_HOLD  = 60
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             tick,
    input  logic                             serve,
    input  logic [9:0]                       paddle_x,
    input  logic [BRICK_ROWS*BRICK_COLS-1:0] brick_alive,
    output logic [9:0]                       x_out,
    output logic [9:0]                       y_out,
    output logic                             brick_hit,
    output logic [7:0]                       brick_idx,
    output logic                             miss,
    output logic [1:0]                       state_out
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_PLAY = 2'b01;
    localparam logic [1:0] ST_MISS = 2'b10;

    localparam int HOLD_W = (MISS_HOLD > 1) ? $clog2(MISS_HOLD) : 1;
    localparam int QW     = PADDLE_W / 4;

    localparam logic signed [10:0] HALF_S  = 11'(BALL_SIZE / 2);
    localparam logic signed [10:0] SIZE_S  = 11'(BALL_SIZE);
    localparam logic signed [10:0] X_MAX_S = 11'(SCREEN_W - BALL_SIZE);
    localparam logic signed [10:0] Y_MISS_S = 11'(SCREEN_H - BALL_SIZE);
    localparam logic signed [10:0] Y_REST_S = 11'(PADDLE_Y - BALL_SIZE);
    localparam logic signed [10:0] PAD_Y_S = 11'(PADDLE_Y);
    localparam logic signed [10:0] SPD_S   = 11'(SPEED);
    localparam logic signed [10:0] MAX_S   = 11'(MAX_SPEED);
    localparam logic signed [10:0] TRACK_S = 11'(PADDLE_W / 2 - BALL_SIZE / 2);
`ifdef BALL_SPEEDUP_EN
    localparam logic signed [10:0] SPEED_STEP = 11'sd1;
`else
    localparam logic signed [10:0] SPEED_STEP = 11'sd0;
`endif

    logic [1:0]         state;
    logic [9:0]         x, y;
    logic signed [10:0] dx, dy, speed;
    logic               serve_pending;
    logic [HOLD_W-1:0]  hold;

    logic signed [10:0] xs, ys, nx, ny, cx, cy, cx_now;
    logic signed [10:0] dx_abs, dy_abs, track, bounce_speed, zone_dx;
    logic signed [11:0] pad_off;
    logic [9:0]         track_x;
    logic               on_paddle;

    logic [BRICK_COLS-1:0] col_match, col_now;
    logic [BRICK_ROWS-1:0] row_match;
    logic                  brick_found, found_now;
    logic [7:0]            found_idx;

    assign xs     = $signed({1'b0, x});
    assign ys     = $signed({1'b0, y});
    assign nx     = xs + dx;
    assign ny     = ys + dy;
    assign cx     = nx + HALF_S;
    assign cy     = ny + HALF_S;
    assign cx_now = xs + HALF_S;
    assign dx_abs = (dx < 11'sd0) ? -dx : dx;
    assign dy_abs = (dy < 11'sd0) ? -dy : dy;

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        col_match = '0;
        col_now   = '0;
        row_match = '0;
        for (int c = 0; c < BRICK_COLS; c++) begin
            col_match[c] = (cx >= 11'(BRICK_X0 + c * BRICK_PX)) &&
                           (cx < 11'(BRICK_X0 + c * BRICK_PX + BRICK_W));
            col_now[c]   = (cx_now >= 11'(BRICK_X0 + c * BRICK_PX)) &&
                           (cx_now < 11'(BRICK_X0 + c * BRICK_PX + BRICK_W));
        end
        for (int r = 0; r < BRICK_ROWS; r++) begin
            row_match[r] = (cy >= 11'(BRICK_Y0 + r * BRICK_PY)) &&
                           (cy < 11'(BRICK_Y0 + r * BRICK_PY + BRICK_H));
        end
    end

    // Cells never overlap, so at most one live brick can contain the centre.
    always_comb begin
        brick_found = 1'b0;
        found_idx   = '0;
        found_now   = 1'b0;
        for (int r = 0; r < BRICK_ROWS; r++) begin
            for (int c = 0; c < BRICK_COLS; c++) begin
                if (row_match[r] && col_match[c] && brick_alive[r * BRICK_COLS + c]) begin
                    brick_found = 1'b1;
                    found_idx   = 8'(r * BRICK_COLS + c);
                    found_now   = col_now[c];
                end
            end
        end
    end

    // Offset is widened to 12 bits so paddle_x near the top of its range cannot wrap.
    assign pad_off   = 12'(cx) - $signed({2'b00, paddle_x});
    assign on_paddle = (dy > 11'sd0) && (ys + SIZE_S <= PAD_Y_S) && (PAD_Y_S < ny + SIZE_S) &&
                       (pad_off >= 12'sd0) && (pad_off < 12'(PADDLE_W));

    assign bounce_speed = (speed < MAX_S) ? speed + SPEED_STEP : speed;

    always_comb begin
        if (pad_off < 12'(QW))
            zone_dx = -(bounce_speed + 11'sd1);
        else if (pad_off < 12'(2 * QW))
            zone_dx = -bounce_speed;
        else if (pad_off < 12'(3 * QW))
            zone_dx = bounce_speed;
        else
            zone_dx = bounce_speed + 11'sd1;
    end

    assign track   = $signed({1'b0, paddle_x}) + TRACK_S;
    assign track_x = (track < 11'sd0) ? 10'd0 :
                     (track > X_MAX_S) ? X_MAX_S[9:0] : track[9:0];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            x             <= 10'((SCREEN_W - BALL_SIZE) / 2);
            y             <= Y_REST_S[9:0];
            dx            <= SPD_S;
            dy            <= -SPD_S;
            speed         <= SPD_S;
            serve_pending <= 1'b0;
            hold          <= '0;
            brick_hit     <= 1'b0;
            brick_idx     <= '0;
            miss          <= 1'b0;
        end else begin
            brick_hit <= 1'b0;
            miss      <= 1'b0;

            if (state == ST_IDLE && tick && serve_pending)
                serve_pending <= 1'b0;
            else if (state == ST_IDLE && serve)
                serve_pending <= 1'b1;

            if (tick) begin
                case (state)
                    ST_IDLE: begin
                        x <= track_x;
                        y <= Y_REST_S[9:0];
                        if (serve_pending) begin
                            state <= ST_PLAY;
                            dx    <= speed;
                            dy    <= -speed;
                        end
                    end
                    ST_PLAY: begin
                        if (brick_found) begin
                            brick_hit <= 1'b1;
                            brick_idx <= found_idx;
                            if (found_now)
                                dy <= -dy;
                            else
                                dx <= -dx;
                        end else if (ny >= Y_MISS_S) begin
                            state <= ST_MISS;
                            miss  <= 1'b1;
                            hold  <= HOLD_W'(MISS_HOLD - 1);
                        end else if (on_paddle) begin
                            x     <= nx[9:0];
                            y     <= Y_REST_S[9:0];
                            dx    <= zone_dx;
                            dy    <= -bounce_speed;
                            speed <= bounce_speed;
                        end else begin
                            if (nx <= 11'sd0) begin
                                x  <= 10'd0;
                                dx <= dx_abs;
                            end else if (nx >= X_MAX_S) begin
                                x  <= X_MAX_S[9:0];
                                dx <= -dx_abs;
                            end else begin
                                x <= nx[9:0];
                            end
                            if (ny <= 11'sd0) begin
                                y  <= 10'd0;
                                dy <= dy_abs;
                            end else begin
                                y <= ny[9:0];
                            end
                        end
                    end
                    ST_MISS: begin
                        if (hold == '0) begin
                            state <= ST_IDLE;
                            dx    <= SPD_S;
                            dy    <= -SPD_S;
                            speed <= SPD_S;
                        end else begin
                            hold <= hold - 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign x_out     = x;
    assign y_out     = y;
    assign state_out = state;

endmodule

// File: tb/tb_ball_engine.sv
// Self-checking bench for ball_engine: a rule-level model compared every cycle, plus hand-computed trajectory pins.
module tb_ball_engine;

    localparam int SW = 640, SH = 480, BS = 7, PW = 100, PY = 440, SPD = 4, MAXS = 8;
    localparam int NC = 5, NR = 5, BX0 = 40, BY0 = 40, BPX = 120, BPY = 50, BW = 80, BH = 30;
    localparam int HOLD = 60;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tick = 1'b0;
    logic        serve = 1'b0;
    logic [9:0]  paddle_x = 10'd100;
    logic [24:0] brick_alive = '1;
    logic [9:0]  x_out, y_out;
    logic        brick_hit, miss;
    logic [7:0]  brick_idx;
    logic [1:0]  state_out;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: position, velocity, speed, state code (0 idle, 1 play, 2 miss), hold, serve latch, pulses.
    int  mx, my, mdx, mdy, mspeed, ms, mhold, midx;
    bit  mpend, mhit, mmiss;

    ball_engine dut (
        .clk(clk), .reset(reset), .tick(tick), .serve(serve), .paddle_x(paddle_x),
        .brick_alive(brick_alive), .x_out(x_out), .y_out(y_out), .brick_hit(brick_hit),
        .brick_idx(brick_idx), .miss(miss), .state_out(state_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset();
        mx = (SW - BS) / 2; my = PY - BS; mdx = SPD; mdy = -SPD; mspeed = SPD;
        ms = 0; mhold = 0; mpend = 0; mhit = 0; mmiss = 0; midx = 0;
    endtask

    task automatic model_step();
        int  nx, ny, cx, cy, col, row, off, v, old_state;
        bit  consume;
        old_state = ms;
        consume = tick && ms == 0 && mpend;
        mhit = 0;
        mmiss = 0;
        if (tick) begin
            if (ms == 0) begin
                v = int'(paddle_x) + PW / 2 - BS / 2;
                if (v > 1023) v -= 2048;
                mx = (v < 0) ? 0 : (v > SW - BS) ? SW - BS : v;
                my = PY - BS;
                if (mpend) begin ms = 1; mdx = mspeed; mdy = -mspeed; end
            end else if (ms == 1) begin
                nx = mx + mdx; ny = my + mdy;
                cx = nx + BS / 2; cy = ny + BS / 2;
                col = -1; row = -1;
                for (int c = 0; c < NC; c++)
                    if (cx >= BX0 + c * BPX && cx < BX0 + c * BPX + BW) col = c;
                for (int r = 0; r < NR; r++)
                    if (cy >= BY0 + r * BPY && cy < BY0 + r * BPY + BH) row = r;
                if (col >= 0 && row >= 0 && brick_alive[row * NC + col]) begin
                    mhit = 1;
                    midx = row * NC + col;
                    if (mx + BS / 2 >= BX0 + col * BPX && mx + BS / 2 < BX0 + col * BPX + BW)
                        mdy = -mdy;
                    else
                        mdx = -mdx;
                end else if (ny >= SH - BS) begin
                    ms = 2; mmiss = 1; mhold = HOLD - 1;
                end else if (mdy > 0 && my + BS <= PY && PY < ny + BS &&
                             cx >= int'(paddle_x) && cx < int'(paddle_x) + PW) begin
`ifdef BALL_SPEEDUP_EN
                    if (mspeed < MAXS) mspeed++;
                    mdy = -mspeed;
`else
                    mdy = -iabs(mdy);
`endif
                    off = (cx - int'(paddle_x)) / (PW / 4);
                    case (off)
                        0: mdx = -(mspeed + 1);
                        1: mdx = -mspeed;
                        2: mdx = mspeed;
                        default: mdx = mspeed + 1;
                    endcase
                    mx = nx; my = PY - BS;
                end else begin
                    if (nx <= 0) begin mx = 0; mdx = iabs(mdx); end
                    else if (nx >= SW - BS) begin mx = SW - BS; mdx = -iabs(mdx); end
                    else mx = nx;
                    if (ny <= 0) begin my = 0; mdy = iabs(mdy); end
                    else my = ny;
                end
            end else begin
                if (mhold == 0) begin ms = 0; mdx = SPD; mdy = -SPD; mspeed = SPD; end
                else mhold--;
            end
        end
        if (consume) mpend = 0;
        else if (serve && old_state == 0) mpend = 1;
    endtask

    always @(posedge clk) begin
        if (!reset) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        check("x_out", int'(x_out), mx);
        check("y_out", int'(y_out), my);
        check("state_out", int'(state_out), ms);
        check("brick_hit", int'(brick_hit), int'(mhit));
        check("miss", int'(miss), int'(mmiss));
        if (mhit) check("brick_idx", int'(brick_idx), midx);
    end

    // Returns just after the tick edge, so pulses caused by this tick are visible.
    task automatic tick_once();
        @(negedge clk); #1 tick = 1'b1;
        @(negedge clk); #1 tick = 1'b0;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick_once();
    endtask

    task automatic serve_pulse();
        @(negedge clk); #1 serve = 1'b1;
        @(negedge clk); #1 serve = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); #1 reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic pin_pos(input string name, input int ex, input int ey);
        check({name, "_x"}, int'(x_out), ex);
        check({name, "_y"}, int'(y_out), ey);
    endtask

    int aims[4] = '{10, 35, 60, 85};
    int p, n;

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_x", int'(x_out), 316);
        check("rst_y", int'(y_out), 433);
        check("rst_state", int'(state_out), 0);
        check("rst_idx", int'(brick_idx), 0);
        #1 reset = 1'b1;

        // Idle tracking, serve, first move.
        tick_once();
        pin_pos("idle_track", 147, 433);
        check("idle_state", int'(state_out), 0);
        serve_pulse();
        tick_once();
        check("serve_state", int'(state_out), 1);
        pin_pos("serve_nomove", 147, 433);
        tick_once();
        pin_pos("first_move", 151, 429);

        // First brick: centre enters brick 22 from below while already inside its column.
        tick_n(40);
        pin_pos("pre_brick", 311, 269);
        tick_once();
        check("brick_hit_pulse", int'(brick_hit), 1);
        check("brick_idx_22", int'(brick_idx), 22);
        pin_pos("brick_hold", 311, 269);
        @(negedge clk); #1;
        check("brick_hit_clear", int'(brick_hit), 0);
        brick_alive[22] = 1'b0;
        tick_once();
        pin_pos("brick_bounce", 315, 273);

        // Free play with the paddle steered into each quarter; the model checks every cycle.
        for (int t = 0; t < 1200; t++) begin
            if (ms == 0) serve_pulse();
            p = mx + BS / 2 + mdx - aims[(t / 40) % 4];
            paddle_x = 10'((p < 0) ? 0 : (p > 540) ? 540 : p);
            tick_once();
            if (mhit) brick_alive[midx] = 1'b0;
        end

        // Force a miss: get into PLAY, then keep the paddle on the far side.
        for (int i = 0; i < 200 && ms != 1; i++) begin
            if (ms == 0) serve_pulse();
            tick_once();
        end
        for (int i = 0; i < 3000 && ms != 2; i++) begin
            paddle_x = (mx < 270) ? 10'd540 : 10'd0;
            tick_once();
            if (mhit) brick_alive[midx] = 1'b0;
        end
        check("miss_reached", ms, 2);
        check("miss_pulse", int'(miss), 1);
        check("miss_state", int'(state_out), 2);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (i == 5) serve_pulse();
            tick_once();
            n++;
            if (state_out == 2'b00) break;
        end
        check("miss_hold_ticks", n, 60);
        tick_once();
        check("miss_serve_ignored", int'(state_out), 0);

        // Reset asserted mid-play aborts immediately.
        serve_pulse();
        tick_n(6);
        @(negedge clk); #1 reset = 1'b0;
        model_reset();
        #1;
        pin_pos("midplay_rst", 316, 433);
        check("midplay_rst_state", int'(state_out), 0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;

        // Dead brick is passed through.
        brick_alive = '1;
        brick_alive[22] = 1'b0;
        paddle_x = 10'd100;
        tick_once();
        serve_pulse();
        tick_n(2);
        tick_n(40);
        tick_once();
        check("dead_brick_nohit", int'(brick_hit), 0);
        pin_pos("dead_brick_pass", 315, 265);

        // Walls and paddle quarter 0 with an empty brick map.
        do_reset();
        brick_alive = '0;
        paddle_x = 10'd540;
        tick_once();
        pin_pos("idle_right", 587, 433);
        serve_pulse();
        tick_once();
        tick_n(12);
        pin_pos("right_wall", 633, 385);
        tick_n(97);
        pin_pos("top_wall", 245, 0);
        tick_once();
        pin_pos("after_top", 241, 4);
        paddle_x = 10'd180;
        tick_n(61);
        pin_pos("left_wall", 0, 248);
        tick_n(46);
        pin_pos("pre_paddle", 184, 432);
        tick_once();
        pin_pos("paddle_q0", 188, 433);
        tick_once();
`ifdef BALL_SPEEDUP_EN
        pin_pos("paddle_q0_next", 182, 428);
`else
        pin_pos("paddle_q0_next", 183, 429);
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
